// File: rtl/conv_single_host.sv
// -----------------------------------------------------------------------------
// conv_single_host
//
// Host-side initiator for the single-PE 3x3 convolution array. A 25-byte
// stream (4x4 activation tile, then 3x3 filter, both row-major) is loaded
// into operand registers that drive the array. The block then enables the
// array, waits for its completion strobe, captures the four 2x2 results and
// streams them out one byte at a time. A run that outlasts TIMEOUT cycles is
// abandoned with a one-cycle err pulse.
//
// Parameters
//   TIMEOUT        maximum number of RUN cycles before done_single must arrive
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   in_valid       upstream byte valid
//   in_data[7:0]   upstream byte
//   in_ready       loader can accept a byte (LOAD state, not in reset)
//   active_single  run enable to the array (registered state decode)
//   a11..a44[7:0]  activation operand registers to the array
//   b11..b33[7:0]  filter operand registers to the array
//   done_single    array completion strobe (only honoured in RUN)
//   c11..c22[7:0]  array results
//   out_valid      result byte valid
//   out_data[7:0]  result byte, order c11, c12, c21, c22
//   out_last       marks the fourth result byte
//   out_ready      downstream accepts the byte
//   err            one-cycle pulse when the run times out
// -----------------------------------------------------------------------------

// Protocol checker bound inside the top level; holds the interface assertions.
module conv_single_host_chk (
    input logic       clk,
    input logic       rst,
    input logic       in_ready,
    input logic       active_single,
    input logic       out_valid,
    input logic       out_ready,
    input logic [7:0] out_data,
    input logic       err
);
    // The array enable and the result port are never active together.
    a_run_send_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(active_single && out_valid));

    // The loader never accepts bytes while the array is running.
    a_load_run_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && active_single));

    // A timeout can only be flagged during a run.
    a_err_in_run: assert property (@(posedge clk) disable iff (rst)
        err |-> active_single);

    // A stalled result byte stays presented and unchanged.
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
endmodule

module conv_single_host #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       active_single,
    output logic [7:0] a11, a12, a13, a14,
    output logic [7:0] a21, a22, a23, a24,
    output logic [7:0] a31, a32, a33, a34,
    output logic [7:0] a41, a42, a43, a44,
    output logic [7:0] b11, b12, b13,
    output logic [7:0] b21, b22, b23,
    output logic [7:0] b31, b32, b33,
    input  logic       done_single,
    input  logic [7:0] c11, c12, c21, c22,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err
);

    localparam int               RUN_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [4:0]       LOAD_LAST = 5'd24;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [4:0]       load_cnt_r;
    logic [RUN_W-1:0] run_cnt_r;
    logic [1:0]       send_idx_r;
    logic [1:0]       send_idx_inc_s;

    logic [7:0]       a_r   [16];
    logic [7:0]       b_r   [9];
    logic [7:0]       res_r [4];

    logic             active_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic             out_last_r;

    logic             load_acc_s;
    logic             load_last_s;
    logic             capture_s;
    logic             timeout_s;
    logic             send_acc_s;
    logic             send_last_s;
    logic [7:0]       out_data_nxt_s;
    logic             out_last_nxt_s;

    // in_ready is forced low during reset so no byte is taken in that cycle.
    assign in_ready       = (state_r == ST_LOAD) && !rst;
    assign active_single  = active_r;
    assign out_valid      = out_valid_r;
    assign out_data       = out_data_r;
    assign out_last       = out_last_r;
    // err must coincide with the cycle the timeout is detected and lose to a
    // simultaneous done, so it is decoded from state rather than registered.
    assign err            = timeout_s;
    assign send_idx_inc_s = send_idx_r + 2'd1;

    assign a11 = a_r[0];   assign a12 = a_r[1];   assign a13 = a_r[2];   assign a14 = a_r[3];
    assign a21 = a_r[4];   assign a22 = a_r[5];   assign a23 = a_r[6];   assign a24 = a_r[7];
    assign a31 = a_r[8];   assign a32 = a_r[9];   assign a33 = a_r[10];  assign a34 = a_r[11];
    assign a41 = a_r[12];  assign a42 = a_r[13];  assign a43 = a_r[14];  assign a44 = a_r[15];
    assign b11 = b_r[0];   assign b12 = b_r[1];   assign b13 = b_r[2];
    assign b21 = b_r[3];   assign b22 = b_r[4];   assign b23 = b_r[5];
    assign b31 = b_r[6];   assign b32 = b_r[7];   assign b33 = b_r[8];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode, handshake strobes and next values of the result port.
    always_comb begin
        state_nxt_s    = state_r;
        load_acc_s     = 1'b0;
        load_last_s    = 1'b0;
        capture_s      = 1'b0;
        timeout_s      = 1'b0;
        send_acc_s     = 1'b0;
        send_last_s    = 1'b0;
        out_data_nxt_s = out_data_r;
        out_last_nxt_s = out_last_r;

        case (state_r)
            ST_LOAD: begin
                load_acc_s  = in_valid && in_ready;
                load_last_s = load_acc_s && (load_cnt_r == LOAD_LAST);
                if (load_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                // done has priority over the timeout check in the same cycle
                capture_s = done_single;
                timeout_s = !done_single && (run_cnt_r == RUN_LAST);
                if (capture_s) begin
                    state_nxt_s    = ST_SEND;
                    out_data_nxt_s = c11;
                    out_last_nxt_s = 1'b0;
                end else if (timeout_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SEND: begin
                send_acc_s  = out_valid_r && out_ready;
                send_last_s = send_acc_s && (send_idx_r == 2'd3);
                if (send_last_s) begin
                    state_nxt_s    = ST_LOAD;
                    out_data_nxt_s = 8'd0;
                    out_last_nxt_s = 1'b0;
                end else if (send_acc_s) begin
                    state_nxt_s    = ST_SEND;
                    out_data_nxt_s = res_r[send_idx_inc_s];
                    out_last_nxt_s = (send_idx_inc_s == 2'd3);
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // Operand registers, result capture and the load/run/send counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                a_r[i] <= 8'd0;
            end
            for (int i = 0; i < 9; i++) begin
                b_r[i] <= 8'd0;
            end
            for (int i = 0; i < 4; i++) begin
                res_r[i] <= 8'd0;
            end
            load_cnt_r <= 5'd0;
            run_cnt_r  <= {RUN_W{1'b0}};
            send_idx_r <= 2'd0;
        end else begin
            if (load_acc_s) begin
                // indices 16..24 have bit 4 set and low bits 0..8: filter slots
                if (load_cnt_r[4]) begin
                    b_r[load_cnt_r[3:0]] <= in_data;
                end else begin
                    a_r[load_cnt_r[3:0]] <= in_data;
                end
                if (load_last_s) begin
                    load_cnt_r <= 5'd0;
                end else begin
                    load_cnt_r <= load_cnt_r + 5'd1;
                end
            end

            // counts RUN cycles; zero on entry and whenever not running
            if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
                run_cnt_r <= run_cnt_r + RUN_ONE;
            end else begin
                run_cnt_r <= {RUN_W{1'b0}};
            end

            if (capture_s) begin
                res_r[0] <= c11;
                res_r[1] <= c12;
                res_r[2] <= c21;
                res_r[3] <= c22;
            end

            if (send_acc_s) begin
                if (send_last_s) begin
                    send_idx_r <= 2'd0;
                end else begin
                    send_idx_r <= send_idx_inc_s;
                end
            end
        end
    end

    // Registered outputs decoded from the next state, so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_last_r  <= 1'b0;
        end else begin
            active_r    <= (state_nxt_s == ST_RUN);
            out_valid_r <= (state_nxt_s == ST_SEND);
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
        end
    end

    conv_single_host_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .in_ready      (in_ready),
        .active_single (active_single),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .err           (err)
    );

endmodule

// File: doc/conv_single_host.md
# conv_single_host

Host-side initiator for the single-PE 3x3 convolution array. It accepts a byte stream holding a 4x4 activation tile and a 3x3 filter, stores them in operand registers and drives them to the array. It then raises `active_single`, waits for `done_single`, captures the four 2x2 results and streams them out over a valid/ready port. It sits between the upstream data source and the single-process array.

## Interface
- `TIMEOUT`, default 64: maximum number of RUN cycles allowed before `done_single` must arrive.
- `clk`  in  1  clock; all logic rises on the positive edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  loader can accept a byte.
- `active_single`  out  1  run enable to the array.
- `a11`..`a44`  out  8 each  activation registers to the array (16 ports).
- `b11`..`b33`  out  8 each  filter registers to the array (9 ports).
- `done_single`  in  1  array completion strobe.
- `c11`, `c12`, `c21`, `c22`  in  8 each  array results.
- `out_valid`  out  1  result byte valid.
- `out_data`  out  8  result byte.
- `out_last`  out  1  marks the 4th result byte.
- `out_ready`  in  1  downstream accepts the byte.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- Three states: LOAD, RUN, SEND. Reset enters LOAD.
- **LOAD**
  - `in_ready` = 1. A byte is accepted when `in_valid` and `in_ready` are both high.
  - A 5-bit `load_cnt` (0..24) selects the destination register.
  - Indices 0..15 fill `a11,a12,a13,a14,a21,...,a44` in row-major order.
  - Indices 16..24 fill `b11,b12,b13,b21,...,b33` in row-major order.
  - Cycles without a handshake leave `load_cnt` and all registers unchanged.
  - Accepting index 24 moves to RUN and clears `load_cnt`.
- **RUN**
  - `active_single` = 1 and `in_ready` = 0. Operand registers are frozen.
  - A cycle counter `run_cnt` starts at 0 on RUN entry.
  - If `done_single` = 1: capture `c11`,`c12`,`c21`,`c22` into result registers `r0`..`r3`, then move to SEND.
  - Else if `run_cnt` = `TIMEOUT`-1: pulse `err` for one cycle, result registers keep their old values, move to LOAD.
- **SEND**
  - `out_valid` = 1. `out_data` = `r[send_idx]`, with `send_idx` 0..3 mapping to c11, c12, c21, c22.
  - `out_last` = 1 when `send_idx` = 3.
  - `send_idx` advances on an `out_valid` and `out_ready` handshake.
  - The handshake at index 3 moves to LOAD and clears `send_idx`.
  - `out_data` is held stable while `out_ready` = 0.
- Data is unsigned 8-bit throughout. The block does no arithmetic on the data; results are passed through exactly as captured.
- `in_valid` is ignored outside LOAD. `done_single` is ignored outside RUN.

## Timing
- Reset values: state LOAD; all counters 0; `a*`, `b*` and `r0`..`r3` all 0; `active_single`, `out_valid`, `out_last` and `err` all 0.
- `in_ready` = 0 while `rst` = 1, and 1 in the first cycle after `rst` falls.
- Last load byte accepted in cycle N: `active_single` = 1 from cycle N+1.
- `done_single` sampled high in cycle M: `active_single` = 0 and `out_valid` = 1 in cycle M+1.
  - `active_single` must not be held high past M; otherwise the array restarts its sequence.
- With the array's 38-step sequence, M = N+38 and the first `out_valid` is at N+39.
- `active_single` is a registered state decode and is glitch-free.
- Timeout: `err` is high in cycle N+`TIMEOUT` and `in_ready` = 1 in the next cycle.
- Reset mid-operation (any state): the next cycle is LOAD with reset values. A partial tile is discarded and no `out_valid` is emitted.
- `done_single` arriving in the same cycle as the timeout check: done wins, results are captured and there is no `err`.
- Back-to-back tiles: after the SEND index-3 handshake in cycle K, `in_ready` = 1 at K+1.

## Test plan
- Load `a` = 1..16 row-major and all `b` = 1, with a real array and `out_ready` tied high.
  - Expect `out_data` = 54, 63, 90, 99 on four consecutive cycles, with `out_last` only on 99.
- Load with `in_valid` deasserted every other cycle.
  - Expect `load_cnt` to advance only on handshakes, RUN entry exactly after 25 accepted bytes, and results identical to the first test.
- Hold `out_ready` = 0 for 3 cycles at SEND entry.
  - Expect `out_data` = 54 held with `out_valid` = 1 and no index advance, then the normal sequence.
- Use a stub array that never asserts done, with `TIMEOUT` = 64.
  - Expect `err` to pulse once at N+64, no `out_valid`, and `in_ready` = 1 at N+65.
- Assert `rst` for one cycle at RUN cycle 10.
  - Expect `active_single` = 0 and `in_ready` = 1 the following cycle, and all `a`/`b` = 0.
- Run two tiles back-to-back, the second with all `a` = 2 and all `b` = 1.
  - Expect the second tile to return 18, 18, 18, 18, and `active_single` low for at least 5 cycles between the runs.
